// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and elaboration helpers for the chunked ripple adder.
// Feature macro ADDER_SUB_EN (subtract mode) is handled in the interface and top.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // A single-chunk build still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// ADDER_SUB_EN adds the sub select, sampled together with a/b.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef ADDER_SUB_EN
    logic             sub;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/seq_chunk_adder_chunk_add.sv
// Narrow combinational adder slice reused every cycle by seq_chunk_adder.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co
);

    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock, LSB first, carry linked by r_carry.
// Defining ADDER_SUB_EN adds a sub input selecting a - b (cin ignored, cout=1 means no borrow).
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | adding chunk r_cnt, busy=1
//   DONE  | result held on sum/cout, out_valid=1, in_ready follows out_ready
import seq_adder_pkg::*;

module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_chunk_adder_if.slave  bus
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = calc_cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
            $error("seq_chunk_adder: CHUNK must be in 1..WIDTH");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_off;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [WIDTH-1:0] w_sum_upd;

    // Subtraction is folded into the operand latch: a + ~b + 1.
`ifdef ADDER_SUB_EN
    assign w_b_in = bus.sub ? ~bus.b : bus.b;
    assign w_c_in = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_in = bus.b;
    assign w_c_in = bus.cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = bus.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

    // Shift the active chunk down to bit 0 so one narrow adder serves every position.
    assign w_off  = 32'(r_cnt) * 32'(CHUNK);
    assign w_a_sh = r_a >> w_off;
    assign w_b_sh = r_b >> w_off;

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .i_a  (w_a_sh[CHUNK-1:0]),
        .i_b  (w_b_sh[CHUNK-1:0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_sum_upd = (r_sum & ~(CHUNK_MASK << w_off)) | (WIDTH'(w_s) << w_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_upd;
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (WIDTH=16 with CHUNK=4 and CHUNK=16 instances).
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_chunk_adder_if #(.WIDTH(16)) bus ();
    seq_chunk_adder_if #(.WIDTH(16)) bus16 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ops(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    // Offers one operand set, waits for the result; completes the output handshake if out_ready=1.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output logic [15:0] s, output logic co, output int lat);
        int g;
        @(negedge clk);
        drive_ops(a, b, cin);
        bus.in_valid = 1'b1;
        g = 0;
        while (!bus.in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 20);
        s  = bus.sum;
        co = bus.cout;
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs [7];
    vec_t b2b  [3];

    initial begin
        logic [15:0] s;
        logic        co;
        int          lat;
        int          acc;
        int          t_prev;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1};

        b2b[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};
        b2b[1] = '{16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1};
        b2b[2] = '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0};

        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        drive_ops(16'h0, 16'h0, 1'b0);
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        bus16.a         = 16'h0;
        bus16.b         = 16'h0;
        bus16.cin       = 1'b0;
`ifdef ADDER_SUB_EN
        bus.sub   = 1'b0;
        bus16.sub = 1'b0;
`endif

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_idle", i), 32'(bus.out_valid), 32'd0);
        end

        // Result stall: DONE must hold and refuse new operands while out_ready=0.
        bus.out_ready = 1'b0;
        run_op(16'hFFFF, 16'hFFFF, 1'b1, s, co, lat);
        check("stall_sum", 32'(s), 32'hFFFF);
        check("stall_cout", 32'(co), 32'd1);
        drive_ops(16'h0001, 16'h0001, 1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold_sum", 32'(bus.sum), 32'hFFFF);
            check("stall_hold_cout", 32'(bus.cout), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("done_in_ready_follows", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("stall_release_idle", 32'(bus.out_valid), 32'd0);
        check("stall_release_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back: in_valid held high, next operands taken on each DONE edge.
        @(negedge clk);
        drive_ops(b2b[0].a, b2b[0].b, b2b[0].cin);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive_ops(b2b[1].a, b2b[1].b, b2b[1].cin);
        acc    = 0;
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!bus.out_valid && lat < 20);
            check($sformatf("b2b%0d_sum", k), 32'(bus.sum), 32'(b2b[k].exp_sum));
            check($sformatf("b2b%0d_cout", k), 32'(bus.cout), 32'(b2b[k].exp_cout));
            check($sformatf("b2b%0d_interval", k), 32'(cyc - t_prev), (k == 0) ? 32'd4 : 32'd5);
            t_prev = cyc;
            @(posedge clk);
            #1;
            if (acc < 2) begin
                acc++;
                check($sformatf("b2b%0d_reaccept", k), 32'(bus.busy), 32'd1);
                if (acc < 2) begin
                    drive_ops(b2b[acc+1].a, b2b[acc+1].b, b2b[acc+1].cin);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else begin
                check("b2b_final_idle", 32'(bus.out_valid), 32'd0);
            end
        end

        // Async reset in the second RUN cycle discards the partial result.
        @(negedge clk);
        drive_ops(16'h00FF, 16'h0001, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrun_rst_sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, s, co, lat);
        check("post_rst_sum", 32'(s), 32'h0002);
        check("post_rst_cout", 32'(co), 32'd0);
        check("post_rst_latency", 32'(lat), 32'd4);

`ifdef ADDER_SUB_EN
        bus.sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, s, co, lat);
        check("sub_borrow_sum", 32'(s), 32'hFFFE);
        check("sub_borrow_cout", 32'(co), 32'd0);
        run_op(16'h0007, 16'h0005, 1'b1, s, co, lat);
        check("sub_noborrow_sum", 32'(s), 32'h0002);
        check("sub_noborrow_cout", 32'(co), 32'd1);
        bus.sub = 1'b0;
`endif

        // CHUNK==WIDTH instance: single RUN cycle.
        @(negedge clk);
        bus16.a        = 16'h8000;
        bus16.b        = 16'h8000;
        bus16.cin      = 1'b0;
        bus16.in_valid = 1'b1;
        check("w16_pre_out_valid", 32'(bus16.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        check("w16_busy", 32'(bus16.busy), 32'd1);
        @(posedge clk);
        #1;
        check("w16_latency1", 32'(bus16.out_valid), 32'd1);
        check("w16_sum", 32'(bus16.sum), 32'h0000);
        check("w16_cout", 32'(bus16.cout), 32'd1);
        @(negedge clk);
        bus16.a        = 16'h1234;
        bus16.b        = 16'h0FFF;
        bus16.cin      = 1'b1;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("w16_b2b_busy", 32'(bus16.busy), 32'd1);
        bus16.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("w16_sum2", 32'(bus16.sum), 32'h2234);
        check("w16_cout2", 32'(bus16.cout), 32'd0);
        @(posedge clk);
        #1;
        check("w16_idle", 32'(bus16.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
